pll_lock_sequencer: RTL and testbench

Reset and lock controller for the core's PLL. Running on the 50 MHz reference clock, it:

- pulses the PLL reset;
- waits for `locked` with a timeout and bounded retries;
- requires lock to stay stable before releasing the core's system reset;
- re-sequences on loss of lock or on a soft-reset request.

It sits between the board reset/OSD reset request and the PLL's `rst`/`locked` pins, and it gates the reset of every core clock domain.

---
 rtl/pll_lock_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock controller: pulses the PLL reset, waits for a filtered lock with a bounded
// number of retries, and holds the core in reset until lock is stable.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_FILTER  = 256,
    parameter int unsigned LOCK_TIMEOUT = 500000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       req_reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    localparam int unsigned MaxAB    = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
    localparam int unsigned MaxParam = (MaxAB > LOCK_TIMEOUT) ? MaxAB : LOCK_TIMEOUT;
    localparam int unsigned CntW     = $clog2(MaxParam) + 1;

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] FilterLast  = CntW'(LOCK_FILTER - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]      RetryMax    = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StFilter,
        StRun,
        StFail
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic [1:0]      sync_q;
    logic            lk;
    logic            pll_rst_q, sys_reset_q, ready_q, fail_q;

    assign lk = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        retry_d = retry_q;
        if (req_reset) begin
            state_d = StResetPll;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == RstLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    // Lock takes precedence over a timeout expiring in the same cycle.
                    if (lk) begin
                        state_d = StFilter;
                        cnt_d   = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_d = '0;
                        if (retry_q == RetryMax) begin
                            state_d = StFail;
                        end else begin
                            state_d = StResetPll;
                            retry_d = retry_q + 4'd1;
                        end
                    end
                end
                StFilter: begin
                    // A dropout restarts the wait with a full timeout; it does not cost a retry.
                    if (!lk) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == FilterLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!lk) begin
                        state_d = StResetPll;
                        retry_d = '0;
                    end
                end
                StFail: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StResetPll;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StResetPll;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= {sync_q[0], pll_locked};
            pll_rst_q   <= (state_d == StResetPll);
            sys_reset_q <= (state_d != StRun);
            ready_q     <= (state_d == StRun);
            fail_q      <= (state_d == StFail);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_CYCLES/LOCK_FILTER/LOCK_TIMEOUT/MAX_RETRY = 4/8/32/2.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst_n;
    logic       req_reset;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    // Output bundle: {pll_rst, sys_reset, ready, fail, retry_cnt[3:0]}
    localparam logic [7:0] ExpRst  = 8'b1100_0000;
    localparam logic [7:0] ExpWait = 8'b0100_0000;
    localparam logic [7:0] ExpRun  = 8'b0010_0000;
    localparam logic [7:0] ExpFail = 8'b0101_0000;

    typedef struct {
        int         n;
        logic       req;
        logic       lock;
        logic [7:0] exp;
        string      tag;
    } vec_t;

    vec_t tbl [8];

    pll_lock_sequencer #(
        .RST_CYCLES  (4),
        .LOCK_FILTER (8),
        .LOCK_TIMEOUT(32),
        .MAX_RETRY   (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .req_reset (req_reset),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_reset (sys_reset),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    task automatic chk(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] got;
        got = {pll_rst, sys_reset, ready, fail, retry_cnt};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got {prst,sys,rdy,fail,retry}=%b expected %b",
                     tag, idx, $time, got, exp);
        end
    endtask

    // Drive inputs now (at a negedge), then check outputs after each of the next n edges.
    task automatic apply(input vec_t v);
        req_reset  = v.req;
        pll_locked = v.lock;
        for (int i = 0; i < v.n; i++) begin
            @(negedge refclk);
            chk(v.tag, i, v.exp);
        end
    endtask

    task automatic run(input int n, input logic req, input logic lock, input logic [7:0] exp,
                       input string tag);
        vec_t v;
        v.n = n; v.req = req; v.lock = lock; v.exp = exp; v.tag = tag;
        apply(v);
    endtask

    initial begin
        // Power-up: lock raised 10 cycles after release, then loss of lock in RUN and relock.
        tbl[0] = '{3,  1'b0, 1'b0, ExpRst,  "pwr_pll_rst"};
        tbl[1] = '{7,  1'b0, 1'b0, ExpWait, "pwr_wait"};
        tbl[2] = '{10, 1'b0, 1'b1, ExpWait, "pwr_sync_filter"};
        tbl[3] = '{3,  1'b0, 1'b1, ExpRun,  "pwr_run"};
        tbl[4] = '{2,  1'b0, 1'b0, ExpRun,  "lol_sync_delay"};
        tbl[5] = '{4,  1'b0, 1'b0, ExpRst,  "lol_pll_rst"};
        tbl[6] = '{10, 1'b0, 1'b1, ExpWait, "lol_relock"};
        tbl[7] = '{2,  1'b0, 1'b1, ExpRun,  "lol_run"};

        rst_n      = 1'b0;
        req_reset  = 1'b0;
        pll_locked = 1'b0;
        @(negedge refclk);
        chk("reset_vals", 0, ExpRst);
        @(negedge refclk);
        chk("reset_vals", 1, ExpRst);
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) apply(tbl[r]);

        // Lock chatter mid-FILTER: one-cycle dropout forces a full re-filter, no retry.
        run(1, 1'b1, 1'b1, ExpRst,  "chat_req");
        run(3, 1'b0, 1'b1, ExpRst,  "chat_pll_rst");
        run(7, 1'b0, 1'b1, ExpWait, "chat_filter");
        run(1, 1'b0, 1'b0, ExpWait, "chat_drop");
        run(10, 1'b0, 1'b1, ExpWait, "chat_refilter");
        run(2, 1'b0, 1'b1, ExpRun,  "chat_run");

        // req_reset held: pulse length counts from the cycle it drops.
        run(3, 1'b1, 1'b1, ExpRst,  "hold_req");
        run(3, 1'b0, 1'b1, ExpRst,  "hold_pll_rst");
        run(9, 1'b0, 1'b1, ExpWait, "hold_filter");
        run(1, 1'b0, 1'b1, ExpRun,  "hold_run");

        // lk arrives on the timeout cycle: lock wins, no retry.
        run(1, 1'b1, 1'b0, ExpRst,  "tie_req");
        run(3, 1'b0, 1'b0, ExpRst,  "tie_pll_rst");
        run(30, 1'b0, 1'b0, ExpWait, "tie_wait");
        run(10, 1'b0, 1'b1, ExpWait, "tie_filter");
        run(2, 1'b0, 1'b1, ExpRun,  "tie_run");

        // Timeouts with retries, ending in FAIL.
        run(1, 1'b1, 1'b0, ExpRst,          "to_req");
        run(3, 1'b0, 1'b0, ExpRst,          "to_pulse0");
        run(32, 1'b0, 1'b0, ExpWait,        "to_wait0");
        run(4, 1'b0, 1'b0, ExpRst | 8'd1,   "to_pulse1");
        run(32, 1'b0, 1'b0, ExpWait | 8'd1, "to_wait1");
        run(4, 1'b0, 1'b0, ExpRst | 8'd2,   "to_pulse2");
        run(32, 1'b0, 1'b0, ExpWait | 8'd2, "to_wait2");
        run(5, 1'b0, 1'b0, ExpFail | 8'd2,  "to_fail");

        // Recovery from FAIL via a one-cycle req_reset.
        run(1, 1'b1, 1'b0, ExpRst,  "rec_req");
        run(3, 1'b0, 1'b0, ExpRst,  "rec_pll_rst");
        run(1, 1'b0, 1'b1, ExpWait, "rec_wait");
        run(9, 1'b0, 1'b1, ExpWait, "rec_filter");
        run(2, 1'b0, 1'b1, ExpRun,  "rec_run");

        // Async reset mid-FILTER takes effect without a clock edge.
        run(1, 1'b1, 1'b1, ExpRst,  "ar_req");
        run(3, 1'b0, 1'b1, ExpRst,  "ar_pll_rst");
        run(4, 1'b0, 1'b1, ExpWait, "ar_filter");
        #2 rst_n = 1'b0;
        #1 chk("ar_immediate", 0, ExpRst);
        @(negedge refclk);
        chk("ar_held", 0, ExpRst);
        rst_n = 1'b1;
        run(3, 1'b0, 1'b1, ExpRst,  "ar_pll_rst_after");
        run(9, 1'b0, 1'b1, ExpWait, "ar_relock");
        run(1, 1'b0, 1'b1, ExpRun,  "ar_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
